// File: rtl/alarm_pkg.sv
// ============================================================================
// Module : alarm_pkg
// Brief  : State codes, key-checker verdicts and helpers for alarm_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alarm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED = 3'd0,
        ST_EXIT     = 3'd1,
        ST_ARMED    = 3'd2,
        ST_ENTRY    = 3'd3,
        ST_ALARM    = 3'd4
    } state_e;

    localparam logic [1:0] KEY_OK    = 2'd0;
    localparam logic [1:0] KEY_ERROR = 2'd2;
    localparam logic [1:0] KEY_NOKEY = 2'd3;

    function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_sequencer_tick_timer.sv
// ============================================================================
// Module : tick_timer
// Brief  : Tick-enabled up-counter; expired flags the tick that completes len.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             tick,
    input  logic [WIDTH-1:0] len,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Deliberately not gated by clr: the owner derives clr from the expiry itself.
    assign expired = tick && (count_q == (len - WIDTH'(1)));

endmodule

`default_nettype wire

// File: rtl/alarm_sequencer.sv
// ============================================================================
// Module : alarm_sequencer
// Brief  : Alarm panel sequencer (arm / exit / entry / siren, failed-code count).
//          Optional lockout enabled by defining ALARM_SEQUENCER_LOCKOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int unsigned EXIT_TICKS    = 30,
    parameter int unsigned ENTRY_TICKS   = 15,
    parameter int unsigned SIREN_TICKS   = 180,
    parameter int unsigned MAX_FAILS     = 3,
    parameter int unsigned LOCKOUT_TICKS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       key_evt,
    input  logic [1:0] key_status,
    input  logic       sensor_trip,
    output logic       checker_clr,
    output logic       siren,
    output logic       armed_led,
    output logic [2:0] state_o,
    output logic [1:0] fail_cnt,
    output logic       locked
);

    localparam int unsigned TMAX = max_of(max_of(EXIT_TICKS, ENTRY_TICKS),
                                          max_of(SIREN_TICKS, LOCKOUT_TICKS));
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    state_e     state_q, state_d;
    logic [1:0] fail_cnt_q, fail_cnt_d;
    logic       siren_q, siren_d;
    logic       armed_led_q, armed_led_d;
    logic       checker_clr_q, checker_clr_d;

    logic          w_locked;
    logic          w_code_ok;
    logic          w_code_err;
    logic          w_lock_start;
    logic          w_lock_done;
    logic          w_state_exp;
    logic          w_state_clr;
    logic [TW-1:0] w_state_len;

`ifdef ALARM_SEQUENCER_LOCKOUT_EN
    logic locked_q, locked_d;
    logic w_lock_exp;

    assign w_locked = locked_q;

    tick_timer #(
        .WIDTH (TW)
    ) u_lock_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!locked_q),
        .tick    (tick),
        .len     (TW'(LOCKOUT_TICKS)),
        .expired (w_lock_exp)
    );
`else
    logic w_unused_cfg;

    assign w_locked     = 1'b0;
    assign w_unused_cfg = (MAX_FAILS == 0);
`endif

    assign w_code_ok  = key_evt && (key_status == KEY_OK)    && !w_locked;
    assign w_code_err = key_evt && (key_status == KEY_ERROR) && !w_locked;

    always_comb begin
        w_state_len = TW'(EXIT_TICKS);
        case (state_q)
            ST_ENTRY: w_state_len = TW'(ENTRY_TICKS);
            ST_ALARM: w_state_len = TW'(SIREN_TICKS);
            default:  w_state_len = TW'(EXIT_TICKS);
        endcase
    end

    // Held clear outside the timed states, so every timed state starts from zero.
    assign w_state_clr = (state_d != state_q) ||
                         !(state_q inside {ST_EXIT, ST_ENTRY, ST_ALARM});

    tick_timer #(
        .WIDTH (TW)
    ) u_state_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (w_state_clr),
        .tick    (tick),
        .len     (w_state_len),
        .expired (w_state_exp)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DISARMED: if (w_code_ok) state_d = ST_EXIT;
            ST_EXIT: begin
                if (w_code_ok)        state_d = ST_DISARMED;
                else if (w_state_exp) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_code_ok)        state_d = ST_DISARMED;
                else if (sensor_trip) state_d = ST_ENTRY;
            end
            ST_ENTRY: begin
                if (w_code_ok)        state_d = ST_DISARMED;
                else if (w_state_exp) state_d = ST_ALARM;
            end
            ST_ALARM: begin
                if (w_code_ok)        state_d = ST_DISARMED;
                else if (w_state_exp) state_d = ST_ARMED;
            end
            default: state_d = ST_DISARMED;
        endcase

        fail_cnt_d = fail_cnt_q;
        if (w_code_ok) begin
            fail_cnt_d = 2'd0;
        end else if (w_code_err && (fail_cnt_q != 2'd3)) begin
            fail_cnt_d = fail_cnt_q + 2'd1;
        end

        w_lock_start = 1'b0;
        w_lock_done  = 1'b0;
`ifdef ALARM_SEQUENCER_LOCKOUT_EN
        locked_d     = locked_q;
        w_lock_start = w_code_err && (fail_cnt_d != fail_cnt_q) &&
                       (32'(fail_cnt_d) == MAX_FAILS);
        w_lock_done  = locked_q && w_lock_exp;
        if (w_lock_start) begin
            locked_d = 1'b1;
            if (state_q inside {ST_EXIT, ST_ARMED, ST_ENTRY}) begin
                state_d = ST_ALARM;
            end
        end else if (w_lock_done) begin
            locked_d   = 1'b0;
            fail_cnt_d = 2'd0;
        end
`endif

        checker_clr_d = (state_d != state_q) || w_code_err || w_lock_done;
        siren_d       = (state_d == ST_ALARM);
        armed_led_d   = state_d inside {ST_EXIT, ST_ARMED, ST_ENTRY, ST_ALARM};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_DISARMED;
            fail_cnt_q    <= 2'd0;
            siren_q       <= 1'b0;
            armed_led_q   <= 1'b0;
            checker_clr_q <= 1'b0;
`ifdef ALARM_SEQUENCER_LOCKOUT_EN
            locked_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            fail_cnt_q    <= fail_cnt_d;
            siren_q       <= siren_d;
            armed_led_q   <= armed_led_d;
            checker_clr_q <= checker_clr_d;
`ifdef ALARM_SEQUENCER_LOCKOUT_EN
            locked_q      <= locked_d;
`endif
        end
    end

    assign state_o     = state_q;
    assign fail_cnt    = fail_cnt_q;
    assign siren       = siren_q;
    assign armed_led   = armed_led_q;
    assign checker_clr = checker_clr_q;
    assign locked      = w_locked;

endmodule

`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
// ============================================================================
// Module : tb_alarm_sequencer
// Brief  : Directed plus random stimulus checked against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alarm_sequencer;

    localparam int EXIT_T  = 30;
    localparam int ENTRY_T = 15;
    localparam int SIREN_T = 180;
    localparam int MAXF    = 3;
    localparam int LOCK_T  = 60;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       key_evt;
    logic [1:0] key_status;
    logic       sensor_trip;
    logic       checker_clr;
    logic       siren;
    logic       armed_led;
    logic [2:0] state_o;
    logic [1:0] fail_cnt;
    logic       locked;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: state number, ticks spent in it, failure count, lockout.
    int m_state, m_elapsed, m_fail, m_lock_el;
    bit m_locked, m_clr;

    alarm_sequencer #(
        .EXIT_TICKS    (EXIT_T),
        .ENTRY_TICKS   (ENTRY_T),
        .SIREN_TICKS   (SIREN_T),
        .MAX_FAILS     (MAXF),
        .LOCKOUT_TICKS (LOCK_T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .key_evt     (key_evt),
        .key_status  (key_status),
        .sensor_trip (sensor_trip),
        .checker_clr (checker_clr),
        .siren       (siren),
        .armed_led   (armed_led),
        .state_o     (state_o),
        .fail_cnt    (fail_cnt),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    function automatic int delay_of(input int s);
        case (s)
            1:       return EXIT_T;
            3:       return ENTRY_T;
            4:       return SIREN_T;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        int nxt;
        int old_fail;
        bit ok, err, lock_end;
        if (reset) begin
            m_state = 0; m_elapsed = 0; m_fail = 0; m_lock_el = 0;
            m_locked = 0; m_clr = 0;
            return;
        end
        ok       = key_evt && (key_status == 2'd0) && !m_locked;
        err      = key_evt && (key_status == 2'd2) && !m_locked;
        lock_end = 0;
        nxt      = m_state;
        if (ok)
            nxt = (m_state == 0) ? 1 : 0;
        else if (tick && delay_of(m_state) != 0 && m_elapsed + 1 == delay_of(m_state))
            nxt = (m_state == 3) ? 4 : 2;
        else if (m_state == 2 && sensor_trip)
            nxt = 3;
        old_fail = m_fail;
        if (ok) m_fail = 0;
        else if (err && m_fail < 3) m_fail = m_fail + 1;
`ifdef ALARM_SEQUENCER_LOCKOUT_EN
        if (m_locked) begin
            if (tick) m_lock_el = m_lock_el + 1;
            if (m_lock_el == LOCK_T) begin
                lock_end = 1; m_locked = 0; m_fail = 0;
            end
        end else if (err && m_fail == MAXF && old_fail != MAXF) begin
            m_locked = 1; m_lock_el = 0;
            if (m_state >= 1 && m_state <= 3) nxt = 4;
        end
`else
        if (old_fail > 3) m_fail = 3;
`endif
        m_clr = (nxt != m_state) || err || lock_end;
        if (nxt != m_state) m_elapsed = 0;
        else if (tick)      m_elapsed = m_elapsed + 1;
        m_state = nxt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_model();
        chk("state_o",     32'(state_o),     32'(m_state));
        chk("siren",       32'(siren),       32'(m_state == 4));
        chk("armed_led",   32'(armed_led),   32'(m_state >= 1 && m_state <= 4));
        chk("fail_cnt",    32'(fail_cnt),    32'(m_fail));
        chk("locked",      32'(locked),      32'(m_locked));
        chk("checker_clr", 32'(checker_clr), 32'(m_clr));
    endtask

    task automatic cyc(input bit t, input bit e, input logic [1:0] ks, input bit tr, input bit r);
        tick = t; key_evt = e; key_status = ks; sensor_trip = tr; reset = r;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 2'd3, 0, 0);
    endtask

    // Each tick is followed by one quiet cycle.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, 2'd3, 0, 0);
            cyc(0, 0, 2'd3, 0, 0);
        end
    endtask

    task automatic code(input logic [1:0] ks);
        cyc(0, 1, ks, 0, 0);
    endtask

    initial begin
        cyc(0, 0, 2'd3, 0, 1);
        cyc(0, 0, 2'd3, 0, 1);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_clr",   32'(checker_clr), 32'd0);
        idle(2);

        // Arm: code OK, exit delay of 30 ticks.
        code(2'd0);
        chk("arm_state", 32'(state_o), 32'd1);
        chk("arm_led",   32'(armed_led), 32'd1);
        chk("arm_clr",   32'(checker_clr), 32'd1);
        ticks(EXIT_T - 1);
        chk("exit_hold", 32'(state_o), 32'd1);
        ticks(1);
        chk("armed", 32'(state_o), 32'd2);

        // Intrusion: entry delay then siren, then auto re-arm.
        cyc(0, 0, 2'd3, 1, 0);
        chk("entry", 32'(state_o), 32'd3);
        ticks(ENTRY_T);
        chk("alarm_state", 32'(state_o), 32'd4);
        chk("alarm_siren", 32'(siren), 32'd1);
        ticks(SIREN_T - 1);
        chk("siren_hold", 32'(siren), 32'd1);
        ticks(1);
        chk("rearm_state", 32'(state_o), 32'd2);
        chk("rearm_siren", 32'(siren), 32'd0);

        // Code OK on the same cycle as the final entry tick wins.
        cyc(0, 0, 2'd3, 1, 0);
        ticks(ENTRY_T - 1);
        cyc(1, 1, 2'd0, 0, 0);
        chk("ok_beats_exp", 32'(state_o), 32'd0);
        chk("ok_no_siren",  32'(siren), 32'd0);
        idle(2);

        // Three wrong codes while disarmed.
        code(2'd2); idle(1);
        chk("fail1", 32'(fail_cnt), 32'd1);
        code(2'd2); idle(1);
        chk("fail2", 32'(fail_cnt), 32'd2);
        code(2'd2);
        chk("fail3", 32'(fail_cnt), 32'd3);
`ifdef ALARM_SEQUENCER_LOCKOUT_EN
        chk("locked_on", 32'(locked), 32'd1);
        idle(1);
        code(2'd0);
        chk("ok_ignored", 32'(state_o), 32'd0);
        ticks(LOCK_T - 1);
        chk("still_locked", 32'(locked), 32'd1);
        ticks(1);
        chk("unlocked", 32'(locked), 32'd0);
        chk("fail_clr",  32'(fail_cnt), 32'd0);
`else
        chk("never_locked", 32'(locked), 32'd0);
        code(2'd2);
        chk("fail_sat", 32'(fail_cnt), 32'd3);
`endif
        code(2'd0);
        chk("ok_exit", 32'(state_o), 32'd1);
        ticks(EXIT_T);

        // Three wrong codes while armed.
        code(2'd2); code(2'd2); code(2'd2);
`ifdef ALARM_SEQUENCER_LOCKOUT_EN
        chk("lock_alarm", 32'(state_o), 32'd4);
        chk("lock_flag",  32'(locked), 32'd1);
        ticks(LOCK_T);
        chk("siren_during_lock", 32'(state_o), 32'd4);
`else
        chk("err_no_state_change", 32'(state_o), 32'd2);
`endif
        code(2'd0);
        chk("disarm", 32'(state_o), 32'd0);

        // Reset in the middle of an alarm.
        code(2'd0); ticks(EXIT_T);
        cyc(0, 0, 2'd3, 1, 0);
        ticks(ENTRY_T);
        code(2'd2);
        ticks(50);
        cyc(0, 0, 2'd3, 0, 1);
        chk("rst_alarm_state", 32'(state_o), 32'd0);
        chk("rst_alarm_siren", 32'(siren), 32'd0);
        chk("rst_alarm_fail",  32'(fail_cnt), 32'd0);
        code(2'd0);
        ticks(EXIT_T - 1);
        chk("timer_cleared", 32'(state_o), 32'd1);
        ticks(1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 3) == 0,
                ($urandom % 6) == 0,
                2'($urandom % 4),
                ($urandom % 8) == 0,
                ($urandom % 400) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
